// File: rtl/clause_eval_pipe.sv
// clause_eval_pipe: two-stage clause classifier (SAT/UNIT/CONFLICT/UNRES) with a per-pass conflict summary.
// Define CLAUSE_EVAL_STATS_EN to add saturating unit_count/conflict_count outputs.
module clause_eval_pipe #(
  parameter int NUM_VARIABLE   = 128,
  parameter int VARIABLE_INDEX = $clog2(NUM_VARIABLE),
  parameter int VAR_PER_CLAUSE = 5,
  parameter int CLAUSE_ID_W    = 10,
  parameter int COUNT_W        = 16
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic                                          in_last,
  input  logic [CLAUSE_ID_W-1:0]                        in_clause_id,
  input  logic [VAR_PER_CLAUSE-1:0][VARIABLE_INDEX-1:0] in_variable,
  input  logic [VAR_PER_CLAUSE-1:0]                     in_mask,
  input  logic [VAR_PER_CLAUSE-1:0]                     in_pole,
  input  logic [VAR_PER_CLAUSE-1:0]                     in_unassign,
  input  logic [VAR_PER_CLAUSE-1:0]                     in_assignment,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [CLAUSE_ID_W-1:0]                        out_clause_id,
  output logic [1:0]                                    out_status,
  output logic [VARIABLE_INDEX-1:0]                     out_implied_var,
  output logic                                          out_implied_val,
  output logic                                          pass_done,
  output logic                                          pass_conflict
`ifdef CLAUSE_EVAL_STATS_EN
  ,
  output logic [COUNT_W-1:0]                            unit_count,
  output logic [COUNT_W-1:0]                            conflict_count
`endif
);
  localparam int CW = $clog2(VAR_PER_CLAUSE + 1);
  logic adv, acc;
  logic s1_valid_q, s1_last_q, s1_true_q, s1_free_val_q;
  logic [CW-1:0] s1_free_q;
  logic [CLAUSE_ID_W-1:0] s1_id_q;
  logic [VARIABLE_INDEX-1:0] s1_free_var_q;
  logic any_true_d, free_val_d;
  logic [CW-1:0] free_cnt_d;
  logic [VARIABLE_INDEX-1:0] free_var_d;
  logic s2_valid_q, s2_last_q, sticky_q;
  logic [1:0] status_d;
  assign adv = ~s2_valid_q | out_ready;
  assign in_ready = adv;
  assign out_valid = s2_valid_q;
  assign acc = s2_valid_q & out_ready & ~flush;
  assign pass_done = acc & s2_last_q;
  assign pass_conflict = pass_done & (sticky_q | (out_status == 2'b11));
  // Lowest-index free slot wins; only meaningful when exactly one slot is free.
  always_comb begin
    any_true_d = 1'b0;
    free_cnt_d = '0;
    free_var_d = '0;
    free_val_d = 1'b0;
    for (int k = VAR_PER_CLAUSE - 1; k >= 0; k--) begin
      any_true_d = any_true_d | (in_mask[k] & ~in_unassign[k] & (in_assignment[k] == in_pole[k]));
      if (in_mask[k] & in_unassign[k]) begin
        free_cnt_d = free_cnt_d + 1'b1;
        free_var_d = in_variable[k];
        free_val_d = in_pole[k];
      end
    end
  end
  always_comb status_d = s1_true_q ? 2'b01 : (s1_free_q == CW'(1)) ? 2'b10 : (s1_free_q == '0) ? 2'b11 : 2'b00;
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_true_q <= 1'b0;
      s1_free_q <= '0;
      s1_id_q <= '0;
      s1_free_var_q <= '0;
      s1_free_val_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q <= 1'b0;
      out_clause_id <= '0;
      out_status <= 2'b00;
      out_implied_var <= '0;
      out_implied_val <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      s1_valid_q <= flush ? 1'b0 : adv ? in_valid : s1_valid_q;
      s2_valid_q <= flush ? 1'b0 : adv ? s1_valid_q : s2_valid_q;
      if (adv) begin
        s1_last_q <= in_last;
        s1_true_q <= any_true_d;
        s1_free_q <= free_cnt_d;
        s1_id_q <= in_clause_id;
        s1_free_var_q <= free_var_d;
        s1_free_val_q <= free_val_d;
        s2_last_q <= s1_last_q;
        out_clause_id <= s1_id_q;
        out_status <= status_d;
        out_implied_var <= (status_d == 2'b10) ? s1_free_var_q : '0;
        out_implied_val <= (status_d == 2'b10) & s1_free_val_q;
      end
      sticky_q <= flush ? 1'b0 : acc ? ~s2_last_q & (sticky_q | (out_status == 2'b11)) : sticky_q;
    end
  end
`ifdef CLAUSE_EVAL_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      unit_count <= '0;
      conflict_count <= '0;
    end else begin
      if (acc & (out_status == 2'b10) & ~&unit_count) unit_count <= unit_count + 1'b1;
      if (acc & (out_status == 2'b11) & ~&conflict_count) conflict_count <= conflict_count + 1'b1;
    end
  end
`else
  logic unused_count_w;
  assign unused_count_w = COUNT_W > 0;
`endif
endmodule

// File: tb/tb_clause_eval_pipe.sv
// tb_clause_eval_pipe: random + directed clauses scored against a queue-based reference model.
module tb_clause_eval_pipe;
  localparam int VI = 7;
  localparam int V = 5;
  localparam int IDW = 10;
  localparam int CNTW = 16;
  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     st;
    logic [VI-1:0]  ivar;
    logic           val;
    logic           last;
  } exp_t;
  logic clock, reset, flush, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [IDW-1:0] in_clause_id, out_clause_id;
  logic [V-1:0][VI-1:0] in_variable;
  logic [V-1:0] in_mask, in_pole, in_unassign, in_assignment;
  logic [1:0] out_status;
  logic [VI-1:0] out_implied_var;
  logic out_implied_val, pass_done, pass_conflict;
  int n_checks = 0, n_fail = 0;
  exp_t q[$];
  bit msticky = 0, flushed_prev = 0, stalling = 0;
`ifdef CLAUSE_EVAL_STATS_EN
  logic [CNTW-1:0] unit_count, conflict_count;
  int m_unit = 0, m_conf = 0;
`endif
  clause_eval_pipe dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_clause_id(in_clause_id), .in_variable(in_variable), .in_mask(in_mask),
    .in_pole(in_pole), .in_unassign(in_unassign), .in_assignment(in_assignment),
    .out_valid(out_valid), .out_ready(out_ready), .out_clause_id(out_clause_id),
    .out_status(out_status), .out_implied_var(out_implied_var), .out_implied_val(out_implied_val),
    .pass_done(pass_done), .pass_conflict(pass_conflict)
`ifdef CLAUSE_EVAL_STATS_EN
    , .unit_count(unit_count), .conflict_count(conflict_count)
`endif
  );
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: a clause is SAT if any literal holds, otherwise classified by how many literals are still open.
  function automatic exp_t model(input logic [IDW-1:0] id, input logic [V-1:0][VI-1:0] v,
                                 input logic [V-1:0] m, p, u, a, input logic l);
    exp_t e;
    int open_slots[$];
    bit sat = 0;
    for (int i = 0; i < V; i++)
      if (m[i]) begin
        if (u[i]) open_slots.push_back(i);
        else if (a[i] == p[i]) sat = 1;
      end
    e.id = id;
    e.last = l;
    e.ivar = '0;
    e.val = 1'b0;
    if (sat) e.st = 2'd1;
    else if (open_slots.size() == 1) begin
      e.st = 2'd2;
      e.ivar = v[open_slots[0]];
      e.val = p[open_slots[0]];
    end else if (open_slots.size() == 0) e.st = 2'd3;
    else e.st = 2'd0;
    return e;
  endfunction
  always @(negedge clock) begin
    if (!reset) begin
      chk(in_ready == (!out_valid || out_ready), "in_ready", in_ready, !out_valid || out_ready);
      if (stalling && out_valid) chk(!in_ready, "stall_in_ready", in_ready, 0);
      if (flush) begin
        q.delete();
        msticky = 0;
        flushed_prev = 1;
        chk(!pass_done, "flush_pass_done", pass_done, 0);
      end else begin
        bit exp_pd, exp_pc;
        exp_pd = 0;
        exp_pc = 0;
        if (flushed_prev) chk(!out_valid, "flush_clear", out_valid, 0);
        flushed_prev = 0;
        if (out_valid) begin
          if (q.size() == 0) chk(0, "spurious_out", out_clause_id, 0);
          else begin
            exp_t e;
            e = q[0];
            chk(out_clause_id == e.id, "clause_id", out_clause_id, e.id);
            chk(out_status == e.st, "status", out_status, e.st);
            chk(out_implied_var == e.ivar, "implied_var", out_implied_var, e.ivar);
            chk(out_implied_val == e.val, "implied_val", out_implied_val, e.val);
            if (out_ready) begin
              void'(q.pop_front());
              if (e.last) begin
                exp_pd = 1;
                exp_pc = msticky || e.st == 2'd3;
                msticky = 0;
              end else msticky = msticky || e.st == 2'd3;
`ifdef CLAUSE_EVAL_STATS_EN
              if (e.st == 2'd2 && m_unit < (1 << CNTW) - 1) m_unit++;
              if (e.st == 2'd3 && m_conf < (1 << CNTW) - 1) m_conf++;
`endif
            end
          end
        end
        chk(pass_done == exp_pd, "pass_done", pass_done, exp_pd);
        if (exp_pd) chk(pass_conflict == exp_pc, "pass_conflict", pass_conflict, exp_pc);
        if (in_valid && in_ready)
          q.push_back(model(in_clause_id, in_variable, in_mask, in_pole, in_unassign, in_assignment, in_last));
      end
    end
  end
  task automatic send(input logic [IDW-1:0] id, input logic [V-1:0][VI-1:0] v,
                      input logic [V-1:0] m, p, u, a, input logic l);
    bit ok;
    in_valid = 1;
    in_clause_id = id;
    in_variable = v;
    in_mask = m;
    in_pole = p;
    in_unassign = u;
    in_assignment = a;
    in_last = l;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clock);
      ok = in_ready;
    end
    if (!ok) chk(0, "accept_timeout", 0, 1);
    @(posedge clock);
    #1 in_valid = 0;
  endtask
  task automatic send_rand(input logic l);
    logic [V-1:0][VI-1:0] v;
    logic [V-1:0] m, p, u, a;
    for (int i = 0; i < V; i++) v[i] = VI'($urandom);
    m = V'($urandom);
    p = V'($urandom);
    u = V'($urandom & $urandom);
    a = V'($urandom);
    if ($urandom_range(0, 1) == 1) a = ~p;
    send(IDW'($urandom), v, m, p, u, a, l);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clock);
    #1 chk(q.size() == 0, "drain", q.size(), 0);
  endtask
  initial begin
    logic [V-1:0][VI-1:0] v;
    bit done;
    for (int i = 0; i < V; i++) v[i] = VI'(i * 11 + 3);
    reset = 1; flush = 0; in_valid = 0; in_last = 0; out_ready = 1;
    in_clause_id = '0; in_variable = '0; in_mask = '0; in_pole = '0; in_unassign = '0; in_assignment = '0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk(!out_valid, "rst_out_valid", out_valid, 0);
    chk(!pass_done, "rst_pass_done", pass_done, 0);
    chk(in_ready, "rst_in_ready", in_ready, 1);
    chk(out_status == 2'b00, "rst_status", out_status, 0);
    chk(out_implied_var == '0, "rst_implied_var", out_implied_var, 0);
    idle(2);
    send(10'd5, v, 5'b00111, 5'b00101, 5'b00100, 5'b00000, 0);
    send(10'd6, v, 5'b00111, 5'b00111, 5'b00100, 5'b00000, 0);
    send(10'd7, v, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0);
    send(10'd8, v, 5'b11111, 5'b10101, 5'b00110, 5'b00000, 0);
    idle(4);
    send(10'd9, v, 5'b00011, 5'b00011, 5'b00000, 5'b00000, 1);
    idle(4);
    send(10'd10, v, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 0);
    send(10'd11, v, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 1);
    idle(4);
    fork
      for (int i = 0; i < 4; i++) send_rand(i == 3);
      begin
        bit seen;
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clock);
          seen = out_valid;
        end
        if (!seen) chk(0, "stall_timeout", 0, 1);
        @(posedge clock);
        #1 out_ready = 0;
        stalling = 1;
        idle(3);
        stalling = 0;
        out_ready = 1;
      end
    join
    drain();
    send(10'd20, v, 5'b00011, 5'b00011, 5'b00000, 5'b00000, 0);
    idle(4);
    send(10'd21, v, 5'b00111, 5'b00111, 5'b00100, 5'b00000, 0);
    send(10'd22, v, 5'b00111, 5'b00111, 5'b00110, 5'b00000, 0);
    flush = 1;
    in_valid = 1;
    in_clause_id = 10'd23;
    in_last = 1;
    @(posedge clock);
    #1 flush = 0;
    in_valid = 0;
    idle(3);
    send(10'd24, v, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 1);
    idle(4);
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_rand($urandom_range(0, 7) == 0);
          if ($urandom_range(0, 4) == 0) idle(1);
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clock);
        #1 out_ready = $urandom_range(0, 3) != 0;
      end
    join
    out_ready = 1;
    drain();
`ifdef CLAUSE_EVAL_STATS_EN
    chk(unit_count == CNTW'(m_unit), "unit_count", unit_count, m_unit);
    chk(conflict_count == CNTW'(m_conf), "conflict_count", conflict_count, m_conf);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
